// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, branch redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      dec_op;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_op,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_op,
    output dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem reads, in-order responses into a small FIFO; a word reaches decode 2 cycles after accept.
// Backpressure: requests stop once outstanding+buffered reaches FIFO_DEPTH; a redirect flushes and drains stale reads.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master fe
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, rsp_pc_q, redirect_tgt;
  logic [CW-1:0]   out_q, out_d, discard_q, discard_d, count_q;
  logic [CW:0]     credit_used;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  entry_t          mem_q [FIFO_DEPTH];
  logic            redirect, req_fire, rsp_fire, drop, push, pop;
  logic            unused_pc_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect      = fe.redirect_valid & (state_q != BOOT);
  assign redirect_tgt  = {fe.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsb = ^fe.redirect_pc[1:0];

  // Credits cover both reads in flight and buffered words, so a response always finds space.
  assign credit_used       = {1'b0, out_q} + {1'b0, count_q};
  assign fe.imem_req_valid = (state_q == RUN) & ~redirect & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign fe.imem_req_addr  = pc_q;
  assign req_fire          = fe.imem_req_valid & fe.imem_req_ready;

  assign rsp_fire = fe.imem_rsp_valid;
  assign drop     = (discard_q != '0);
  assign push     = rsp_fire & ~drop & ~redirect;
  assign out_d    = out_q + CW'(req_fire) - CW'(rsp_fire);

  assign fe.dec_valid = (count_q != '0) & ~redirect;
  assign pop          = fe.dec_valid & fe.dec_ready;
  assign fe.dec_instr = mem_q[rd_ptr_q].instr;
  assign fe.dec_pc    = mem_q[rd_ptr_q].pc;
  assign fe.dec_op    = mem_q[rd_ptr_q].instr[6:0];

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    // Every read still in flight at a redirect belongs to the old path.
    if (redirect) begin
      discard_d = out_d;
    end else if (rsp_fire && drop) begin
      discard_d = discard_q - CW'(1);
    end
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect && (out_d != '0)) state_d = DRAIN;
      DRAIN:   if (!redirect && (discard_d == '0)) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      if (redirect) begin
        pc_q     <= redirect_tgt;
        rsp_pc_q <= redirect_tgt;
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (push)     rsp_pc_q <= rsp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: fe.imem_rsp_data};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(32)) ifc ();
  instr_fetch_if #(.XLEN(32)) wfc ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fe(ifc)
  );
  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fe(wfc)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rsp_rand = 1'b0;
  logic [31:0] dmix = 32'h0;

  // Model: reads in flight (address, due cycle, stale flag) and words buffered for decode.
  typedef struct { logic [31:0] addr; int due; bit stale; } rd_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  rd_t  mq[$];
  ent_t bq[$];
  logic [31:0] m_pc;
  bit m_boot, m_drain;
  int last_due;

  logic        s_req_v, s_dec_v;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [6:0]  s_op;

  typedef struct {
    bit rst; int lat; bit rdy; bit drdy; bit redir; logic [31:0] rpc;
    bit ereq; logic [31:0] eaddr; bit edec; logic [31:0] epc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, int lat, bit rdy, bit drdy, bit redir, logic [31:0] rpc,
                              bit ereq, logic [31:0] eaddr, bit edec, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.lat = lat; v.rdy = rdy; v.drdy = drdy; v.redir = redir; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.edec = edec; v.epc = epc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ dmix;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    ifc.imem_req_ready = 1'b0; ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = '0;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0; ifc.dec_ready = 1'b0;
    wfc.imem_req_ready = 1'b0; wfc.imem_rsp_valid = 1'b0; wfc.imem_rsp_data = '0;
    wfc.redirect_valid = 1'b0; wfc.redirect_pc = '0; wfc.dec_ready = 1'b0;
  endtask

  // Reset is asserted mid-cycle; optionally confirm outputs clear without a clock edge.
  task automatic do_reset(input bit check_zero);
    #3;
    rst_n = 1'b0;
    drive_idle();
    if (check_zero) begin
      #1;
      chk("rst_req_valid", {31'b0, ifc.imem_req_valid}, 32'h0);
      chk("rst_dec_valid", {31'b0, ifc.dec_valid}, 32'h0);
      chk("rst_dec_instr", ifc.dec_instr, 32'h0);
      chk("rst_dec_pc", ifc.dec_pc, 32'h0);
      chk("rst_dec_op", {25'b0, ifc.dec_op}, 32'h0);
    end
    mq.delete(); bq.delete();
    m_pc = 32'h0; m_boot = 1'b1; m_drain = 1'b0; last_due = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    bit rsp, e_req, e_dec, eff;
    int due;
    rd_t h;
    @(negedge clk);
    rsp = (mq.size() > 0) && (mq[0].due <= cyc) && (!rsp_rand || ($urandom % 4 != 0));
    ifc.imem_req_ready = rdy;
    ifc.imem_rsp_valid = rsp;
    ifc.imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
    ifc.redirect_valid = redir;
    ifc.redirect_pc    = rpc;
    ifc.dec_ready      = drdy;
    #1;
    s_req_v = ifc.imem_req_valid; s_addr = ifc.imem_req_addr;
    s_dec_v = ifc.dec_valid; s_pc = ifc.dec_pc; s_instr = ifc.dec_instr; s_op = ifc.dec_op;
    e_req = !m_boot && !m_drain && !redir && (mq.size() + bq.size() < 2);
    e_dec = (bq.size() > 0) && !redir;
    chk("req_valid", {31'b0, s_req_v}, {31'b0, e_req});
    if (e_req) chk("req_addr", s_addr, m_pc);
    chk("dec_valid", {31'b0, s_dec_v}, {31'b0, e_dec});
    if (e_dec) begin
      chk("dec_pc", s_pc, bq[0].pc);
      chk("dec_instr", s_instr, bq[0].instr);
      chk("dec_op", {25'b0, s_op}, {25'b0, bq[0].instr[6:0]});
    end
    @(posedge clk);
    eff = redir && !m_boot;
    if (e_dec && drdy) void'(bq.pop_front());
    if (rsp) begin
      h = mq.pop_front();
      if (!h.stale && !eff) bq.push_back('{pc: h.addr, instr: mem_word(h.addr)});
    end
    if (e_req && rdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: m_pc, due: due, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (eff) begin
      bq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
      m_drain = m_drain || (mq.size() > 0);
    end else if (m_drain) begin
      m_drain = (mq.size() > 0) && mq[0].stale;
    end
    m_boot = 1'b0;
    cyc++;
  endtask

  initial begin
    bit          pend, v;
    logic [31:0] paddr, a;
    logic [31:0] wexp[3];
    int          nreq, ndec;

    drive_idle();

    // Stream with ready memory and decode (1-cycle responses).
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h4, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'hC, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 32'h8));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'hC));
    // Decode backpressure from reset, then release.
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h4, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h8, 1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'hC, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 32'h8));
    // Misaligned redirect with two reads in flight (3-cycle memory).
    tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h4, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 1, 32'h103, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h104, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 1, 32'h100));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h108, 1, 32'h104));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(1'b0);
      lat_min = tbl[i].lat;
      lat_max = tbl[i].lat;
      step(tbl[i].rdy, tbl[i].drdy, tbl[i].redir, tbl[i].rpc);
      chk("tbl_req_valid", {31'b0, s_req_v}, {31'b0, tbl[i].ereq});
      if (tbl[i].ereq) chk("tbl_req_addr", s_addr, tbl[i].eaddr);
      chk("tbl_dec_valid", {31'b0, s_dec_v}, {31'b0, tbl[i].edec});
      if (tbl[i].edec) chk("tbl_dec_pc", s_pc, tbl[i].epc);
    end

    // Redirect coinciding with a response and a ready decoder while the FIFO holds a word.
    do_reset(1'b0);
    lat_min = 1; lat_max = 1;
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 32'h200);
    chk("t4_dec_valid_at_redirect", {31'b0, s_dec_v}, 32'h0);
    chk("t4_req_valid_at_redirect", {31'b0, s_req_v}, 32'h0);
    step(1, 1, 0, 0);
    chk("t4_dec_valid_after", {31'b0, s_dec_v}, 32'h0);
    chk("t4_req_addr_after", s_addr, 32'h200);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t4_first_dec_valid", {31'b0, s_dec_v}, 32'h1);
    chk("t4_first_dec_pc", s_pc, 32'h200);

    // Asynchronous reset while draining, after the FIFO has held data.
    do_reset(1'b0);
    lat_min = 1; lat_max = 1;
    repeat (4) step(1, 1, 0, 0);
    lat_min = 3; lat_max = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h40);
    chk("t6_req_valid_at_redirect", {31'b0, s_req_v}, 32'h0);
    do_reset(1'b1);
    lat_min = 1; lat_max = 1;
    step(1, 1, 0, 0);
    chk("t6_boot_no_req", {31'b0, s_req_v}, 32'h0);
    step(1, 1, 0, 0);
    chk("t6_first_req_valid", {31'b0, s_req_v}, 32'h1);
    chk("t6_first_req_addr", s_addr, 32'h0);

    // PC wrap from RESET_PC = FFFF_FFFC on the second instance.
    do_reset(1'b0);
    wexp[0] = 32'hFFFF_FFFC; wexp[1] = 32'h0000_0000; wexp[2] = 32'h0000_0004;
    pend = 1'b0; paddr = '0; nreq = 0; ndec = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      wfc.imem_req_ready = 1'b1;
      wfc.dec_ready      = 1'b1;
      wfc.imem_rsp_valid = pend;
      wfc.imem_rsp_data  = paddr ^ 32'hA5A5_0000;
      #1;
      v = wfc.imem_req_valid;
      a = wfc.imem_req_addr;
      if (v && nreq < 3) begin
        chk("wrap_req_addr", a, wexp[nreq]);
        nreq++;
      end
      if (wfc.dec_valid && ndec < 3) begin
        chk("wrap_dec_pc", wfc.dec_pc, wexp[ndec]);
        chk("wrap_dec_instr", wfc.dec_instr, wexp[ndec] ^ 32'hA5A5_0000);
        ndec++;
      end
      @(posedge clk);
      pend = v;
      paddr = a;
    end
    chk("wrap_req_count", nreq, 32'd3);
    chk("wrap_dec_count", ndec, 32'd3);

    // Randomized traffic: variable latency, response stalls, backpressure, redirects.
    do_reset(1'b0);
    dmix = $urandom;
    lat_min = 1; lat_max = 3; rsp_rand = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      bit redir;
      redir = !m_boot && ($urandom % 20 == 0);
      step($urandom % 4 != 0, $urandom % 3 != 0, redir, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
